evm_poll_controller: RTL and testbench

//  Parametrised election core: N_CAND vote counters, N_VOTER voted-flags, poll FSM.

---
 rtl/evm_poll_controller.sv | 182 ++++++++++++++++++
 tb/tb_evm_poll_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/evm_poll_controller.sv
// Election core for the EVM: per-candidate vote counters, per-voter voted flags,
// poll FSM and a sequential winner scan. Optional tie flag when EVM_TIE_DETECT_EN is defined.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | after reset, no poll yet; votes nacked
//   S_OPEN  | poll running; votes evaluated and counted
//   S_TALLY | scanning one candidate per cycle for the maximum
//   S_DONE  | winner/max_votes registered and valid; votes nacked
module evm_poll_controller #(
    parameter int N_CAND  = 3,
    parameter int N_VOTER = 4,
    parameter int CAND_W  = 4,
    parameter int VOTER_W = 4,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               open_poll,
    input  logic               close_poll,
    input  logic               vote_cast,
    input  logic [VOTER_W-1:0] voter_id,
    input  logic [CAND_W-1:0]  candidate_number,
    output logic               vote_ack,
    output logic               vote_nack,
    output logic [1:0]         poll_state,
    output logic [CNT_W-1:0]   total_votes,
    output logic [CAND_W-1:0]  winner,
    output logic [CNT_W-1:0]   max_votes,
    output logic               winner_valid
`ifdef EVM_TIE_DETECT_EN
    ,
    output logic               tie
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_OPEN  = 2'b01,
        S_TALLY = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt [N_CAND];
    logic [N_VOTER-1:0] voted;
    logic [CAND_W-1:0]  scan_idx;
    logic [CAND_W-1:0]  best_idx;
    logic [CNT_W-1:0]   best_val;

    logic [N_CAND-1:0]  cand_hit;
    logic [N_VOTER-1:0] voter_hit;
    logic               cand_full;
    logic               vote_ok;
    logic               enter_open;

    logic [CNT_W-1:0]   scan_val;
    logic               scan_last;
    logic               take;
    logic [CNT_W-1:0]   best_val_nxt;
    logic [CAND_W-1:0]  best_idx_nxt;

    // Decoding by equality against each legal index also rejects out-of-range ids.
    always_comb begin
        cand_hit  = '0;
        voter_hit = '0;
        cand_full = 1'b0;
        for (int i = 0; i < N_CAND; i++) begin
            cand_hit[i] = (candidate_number == CAND_W'(i));
            if (cand_hit[i] && (cnt[i] == {CNT_W{1'b1}}))
                cand_full = 1'b1;
        end
        for (int v = 0; v < N_VOTER; v++)
            voter_hit[v] = (voter_id == VOTER_W'(v));
        vote_ok = vote_cast && (state == S_OPEN) && (|cand_hit) && (|voter_hit)
                  && !(|(voter_hit & voted)) && !cand_full;
    end

    assign enter_open = open_poll && ((state == S_IDLE) || (state == S_DONE));

    always_comb begin
        scan_val = '0;
        for (int i = 0; i < N_CAND; i++)
            if (scan_idx == CAND_W'(i))
                scan_val = cnt[i];
        scan_last = (scan_idx == CAND_W'(N_CAND - 1));
        // Strictly-greater replacement keeps the lowest index on ties.
        take         = (scan_idx == '0) || (scan_val > best_val);
        best_val_nxt = take ? scan_val : best_val;
        best_idx_nxt = take ? scan_idx : best_idx;
    end

`ifdef EVM_TIE_DETECT_EN
    logic tie_nxt;
    logic eq_seen;

    always_comb begin
        tie_nxt = 1'b0;
        eq_seen = 1'b0;
        for (int i = 0; i < N_CAND; i++) begin
            if (cnt[i] == best_val_nxt) begin
                if (eq_seen)
                    tie_nxt = 1'b1;
                eq_seen = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (open_poll)  state_nxt = S_OPEN;
            S_OPEN:  if (close_poll) state_nxt = S_TALLY;
            S_TALLY: if (scan_last)  state_nxt = S_DONE;
            S_DONE:  if (open_poll)  state_nxt = S_OPEN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            voted       <= '0;
            total_votes <= '0;
            winner      <= '0;
            max_votes   <= '0;
            best_idx    <= '0;
            best_val    <= '0;
            scan_idx    <= '0;
            vote_ack    <= 1'b0;
            vote_nack   <= 1'b0;
            for (int i = 0; i < N_CAND; i++)
                cnt[i] <= '0;
`ifdef EVM_TIE_DETECT_EN
            tie         <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            vote_ack  <= vote_ok;
            vote_nack <= vote_cast && !vote_ok;
            scan_idx  <= (state == S_TALLY) ? scan_idx + CAND_W'(1) : '0;

            if (enter_open) begin
                voted       <= '0;
                total_votes <= '0;
                winner      <= '0;
                max_votes   <= '0;
                best_idx    <= '0;
                best_val    <= '0;
                for (int i = 0; i < N_CAND; i++)
                    cnt[i] <= '0;
`ifdef EVM_TIE_DETECT_EN
                tie         <= 1'b0;
`endif
            end else if (vote_ok) begin
                voted       <= voted | voter_hit;
                total_votes <= total_votes + CNT_W'(1);
                for (int i = 0; i < N_CAND; i++)
                    if (cand_hit[i])
                        cnt[i] <= cnt[i] + CNT_W'(1);
            end

            if (state == S_TALLY) begin
                best_val <= best_val_nxt;
                best_idx <= best_idx_nxt;
                if (scan_last) begin
                    winner    <= best_idx_nxt;
                    max_votes <= best_val_nxt;
`ifdef EVM_TIE_DETECT_EN
                    tie       <= tie_nxt;
`endif
                end
            end
        end
    end

    assign poll_state   = state;
    assign winner_valid = (state == S_DONE);

endmodule

// File: tb/tb_evm_poll_controller.sv
// Directed and randomized bench for evm_poll_controller against an election-level model.
// Build with EVM_TIE_DETECT_EN defined to also check the tie output.
module tb_evm_poll_controller;

    localparam int NC = 3;
    localparam int NV = 4;
    localparam int CW = 4;
    localparam int VW = 4;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          open_poll = 1'b0;
    logic          close_poll = 1'b0;
    logic          vote_cast = 1'b0;
    logic [VW-1:0] voter_id = '0;
    logic [CW-1:0] candidate_number = '0;
    logic          vote_ack;
    logic          vote_nack;
    logic [1:0]    poll_state;
    logic [NW-1:0] total_votes;
    logic [CW-1:0] winner;
    logic [NW-1:0] max_votes;
    logic          winner_valid;
`ifdef EVM_TIE_DETECT_EN
    logic          tie;
`endif

    evm_poll_controller #(
        .N_CAND(NC), .N_VOTER(NV), .CAND_W(CW), .VOTER_W(VW), .CNT_W(NW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .open_poll(open_poll),
        .close_poll(close_poll),
        .vote_cast(vote_cast),
        .voter_id(voter_id),
        .candidate_number(candidate_number),
        .vote_ack(vote_ack),
        .vote_nack(vote_nack),
        .poll_state(poll_state),
        .total_votes(total_votes),
        .winner(winner),
        .max_votes(max_votes),
        .winner_valid(winner_valid)
`ifdef EVM_TIE_DETECT_EN
        ,
        .tie(tie)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: 0 idle, 1 open, 2 tally, 3 done
    int m_state;
    int m_cnt [NC];
    bit m_voted [NV];
    int m_total, m_winner, m_max, m_left;
    int m_pend_w, m_pend_m;
    bit m_tie, m_pend_tie;
    bit m_ack, m_nack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NC; c++) m_cnt[c] = 0;
        for (int v = 0; v < NV; v++) m_voted[v] = 0;
        m_total = 0; m_winner = 0; m_max = 0; m_tie = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_state = 0; m_left = 0; m_ack = 0; m_nack = 0;
    endtask

    task automatic model_edge(input bit op, input bit cl, input bit vc, input int vid, input int cand);
        int w, eq;
        m_ack = 0;
        m_nack = 0;
        case (m_state)
            1: begin
                if (vc) begin
                    if (vid < NV && cand < NC && !m_voted[vid] && m_cnt[cand] != (1 << NW) - 1) begin
                        m_ack = 1;
                        m_cnt[cand]++;
                        m_voted[vid] = 1;
                        m_total++;
                    end else m_nack = 1;
                end
                if (cl) begin
                    w = 0;
                    for (int c = 1; c < NC; c++) if (m_cnt[c] > m_cnt[w]) w = c;
                    eq = 0;
                    for (int c = 0; c < NC; c++) if (m_cnt[c] == m_cnt[w]) eq++;
                    m_pend_w = w;
                    m_pend_m = m_cnt[w];
                    m_pend_tie = (eq >= 2);
                    m_left = NC;
                    m_state = 2;
                end
            end
            2: begin
                if (vc) m_nack = 1;
                m_left--;
                if (m_left == 0) begin
                    m_state = 3;
                    m_winner = m_pend_w;
                    m_max = m_pend_m;
                    m_tie = m_pend_tie;
                end
            end
            default: begin
                if (vc) m_nack = 1;
                if (op) begin
                    model_clear();
                    m_state = 1;
                end
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, " ack"}, vote_ack, m_ack);
        check({tag, " nack"}, vote_nack, m_nack);
        check({tag, " state"}, poll_state, m_state);
        check({tag, " total"}, total_votes, m_total);
        check({tag, " valid"}, winner_valid, m_state == 3);
        check({tag, " winner"}, winner, m_winner);
        check({tag, " max"}, max_votes, m_max);
`ifdef EVM_TIE_DETECT_EN
        check({tag, " tie"}, tie, m_tie);
`endif
    endtask

    task automatic step(input string tag, input bit op, input bit cl, input bit vc,
                        input int vid, input int cand);
        open_poll = op;
        close_poll = cl;
        vote_cast = vc;
        voter_id = VW'(vid);
        candidate_number = CW'(cand);
        model_edge(op, cl, vc, vid, cand);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        open_poll = 0; close_poll = 0; vote_cast = 0;
        @(posedge clk);
        #1;
        model_reset();
        check_all(tag);
        rst_n = 1'b1;
    endtask

    task automatic vote(input string tag, input int vid, input int cand);
        step(tag, 0, 0, 1, vid, cand);
    endtask

    task automatic close_and_tally(input string tag);
        step(tag, 0, 1, 0, 0, 0);
        for (int k = 1; k <= NC; k++) begin
            step(tag, 0, 0, 0, 0, 0);
            check({tag, " latency"}, winner_valid, (k == NC) ? 1 : 0);
        end
    endtask

    initial begin
        model_reset();
        #2;

        // T1: basic poll
        do_reset("T1 reset");
        check("T1 reset state", poll_state, 0);
        step("T1 open", 1, 0, 0, 0, 0);
        vote("T1 v0c1", 0, 1);
        vote("T1 v1c1", 1, 1);
        vote("T1 v2c0", 2, 0);
        close_and_tally("T1");
        check("T1 winner", winner, 1);
        check("T1 max", max_votes, 2);
        check("T1 total", total_votes, 3);

        // T2: duplicate voter
        step("T2 open", 1, 0, 0, 0, 0);
        vote("T2 first", 0, 2);
        check("T2 first ack", vote_ack, 1);
        vote("T2 dup", 0, 2);
        check("T2 dup nack", vote_nack, 1);
        close_and_tally("T2");
        check("T2 winner", winner, 2);
        check("T2 max", max_votes, 1);
        check("T2 total", total_votes, 1);

        // T3: out-of-range voter and candidate
        step("T3 open", 1, 0, 0, 0, 0);
        vote("T3 bad voter", 4, 0);
        check("T3 bad voter nack", vote_nack, 1);
        vote("T3 bad cand", 0, 3);
        check("T3 bad cand nack", vote_nack, 1);
        close_and_tally("T3");
        check("T3 winner", winner, 0);
        check("T3 max", max_votes, 0);
        check("T3 total", total_votes, 0);

        // T4: tie resolves to lowest index
        step("T4 open", 1, 0, 0, 0, 0);
        vote("T4 v0c0", 0, 0);
        vote("T4 v1c2", 1, 2);
        close_and_tally("T4");
        check("T4 winner", winner, 0);
        check("T4 max", max_votes, 1);
`ifdef EVM_TIE_DETECT_EN
        check("T4 tie", tie, 1);
`endif

        // T5: vote together with close
        step("T5 open", 1, 0, 0, 0, 0);
        step("T5 vote+close", 0, 1, 1, 0, 1);
        check("T5 ack", vote_ack, 1);
        step("T5 late vote", 0, 0, 1, 1, 1);
        check("T5 late nack", vote_nack, 1);
        for (int k = 0; k < NC - 1; k++) step("T5 tally", 0, 0, 0, 0, 0);
        check("T5 winner", winner, 1);
        check("T5 max", max_votes, 1);

        // T6: reset during tally
        step("T6 open", 1, 0, 0, 0, 0);
        vote("T6 v3c2", 3, 2);
        step("T6 close", 0, 1, 0, 0, 0);
        step("T6 tally", 0, 0, 0, 0, 0);
        do_reset("T6 reset");
        step("T6 reopen", 1, 0, 0, 0, 0);
        check("T6 state", poll_state, 1);
        check("T6 total", total_votes, 0);
        check("T6 valid", winner_valid, 0);
        close_and_tally("T6 empty");
        check("T6 max", max_votes, 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset("RND reset");
            end else begin
                step("RND",
                     $urandom_range(0, 99) < 30,
                     $urandom_range(0, 99) < 8,
                     $urandom_range(0, 99) < 60,
                     int'($urandom_range(0, 5)),
                     int'($urandom_range(0, 4)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
